program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/prog_mem.sv | 44 ++++
 rtl/program_loader.sv | 99 +++++++++
 tb/tb_program_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader slice.
// Holds the default widths and the loader FSM state encoding.
// The state constants are plain logic [1:0] localparams, so the FSM
// code can treat the state as an ordinary vector.
package loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int NIB_W_DEF  = 4;

  // Loader FSM states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HI   = 2'd1;
  localparam logic [1:0] LO   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/prog_mem.sv
// Program storage: 2**ADDR_W x DATA_W words.
// It has one synchronous write port, which reset clears, and one
// asynchronous read port.
// Ports:
//   clk, rst         clock and synchronous active-high clear of every word
//   wr_en            write enable for wr_addr/wr_data on the rising edge
//   wr_addr, wr_data write address and data
//   rd_addr, rd_data combinational read port (the CPU fetch side)
module prog_mem
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset wipes the whole program. This means a reset can never leave
  // behind a stale or partially loaded image.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read returns the value stored before the edge. A new write
  // becomes visible in the following cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Program loader: fills program memory from a nibble stream and serves
// CPU instruction fetches. The fetch side is a drop-in replacement for
// the old program ROM port pair.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   load_start           one-cycle request to start a session (honoured only in IDLE)
//   nib_valid, nib_data  loader stream, high nibble of each byte first
//   nib_ready            stream transfer allowed (HI or LO state)
//   addr, prog           CPU fetch address and combinational instruction
//   busy                 session in progress; the CPU holds its PC while high
//   done                 one-cycle pulse after the last location is written
//   checksum             modulo-2**DATA_W sum of the bytes written in this/last session
// DATA_W must equal 2*NIB_W.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NIB_W  = NIB_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              nib_valid,
  input  logic [NIB_W-1:0]  nib_data,
  output logic              nib_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] prog,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [NIB_W-1:0]  hi_nib;
  logic              hs;
  logic              wr_en;
  logic [DATA_W-1:0] wr_byte;

  assign nib_ready = (state == HI) || (state == LO);
  assign hs        = nib_ready && nib_valid;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign wr_byte   = {hi_nib, nib_data};

  // Gating with rst drops a LO handshake that coincides with reset.
  // Otherwise that byte would be written alongside the memory clear.
  assign wr_en = hs && (state == LO) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      hi_nib   <= '0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= HI;
            wr_ptr   <= '0;
            checksum <= '0;
          end
        end
        HI: begin
          if (hs) begin
            hi_nib <= nib_data;
            state  <= LO;
          end
        end
        LO: begin
          if (hs) begin
            checksum <= checksum + wr_byte;
            // The pointer wraps naturally to 0 on the last location.
            wr_ptr   <= wr_ptr + 1'b1;
            state    <= (wr_ptr == '1) ? DONE : HI;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  prog_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(wr_byte),
    .rd_addr(addr),
    .rd_data(prog)
  );

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader.
// Inputs are driven and outputs are checked on the falling clock edge.
// Bytes written by the stream are pushed to a scoreboard queue and a
// memory model when driven. They are popped and compared against prog
// once the session ends.
module tb_program_loader;
  import loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic       nib_valid;
  logic [3:0] nib_data;
  logic       nib_ready;
  logic [3:0] addr;
  logic [7:0] prog;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  program_loader #(.ADDR_W(4), .DATA_W(8), .NIB_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .nib_valid (nib_valid),
    .nib_data  (nib_data),
    .nib_ready (nib_ready),
    .addr      (addr),
    .prog      (prog),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } sb_t;

  vec_t       vtab [16];
  sb_t        sb_q [$];
  logic [7:0] exp_mem [16];
  logic [7:0] load_bytes [16];
  logic [7:0] exp_sum;
  int         total = 0;
  int         passed = 0;
  int         done_count = 0;
  int         dc0;

  // done is sampled before the edge updates it, so each pulse counts once.
  always @(posedge clk) if (done === 1'b1) done_count++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic ls, input logic v, input logic [3:0] d);
    load_start = ls;
    nib_valid  = v;
    nib_data   = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    sb_q.delete();
    exp_sum = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic apply_table(input string name);
    for (int i = 0; i < 16; i++) begin
      addr = vtab[i].addr;
      #1;
      check_output(name, 32'(prog), 32'(vtab[i].exp));
      tick();
    end
  endtask

  // Runs one session from load_start. With abort_after >= 0 it returns
  // after that many nibbles have been presented, with the session still open.
  task automatic run_load(input bit toggle, input bit poke, input bit watch5, input int abort_after);
    int         k;
    bit         ph;
    bit         chk5;
    logic [7:0] b;
    sb_t        e;
    exp_sum = 8'h00;
    dc0 = done_count;
    apply_stimulus(1'b1, 1'b0, 4'h0);
    tick();
    check_output("busy_after_start", 32'(busy), 32'd1);
    check_output("ready_after_start", 32'(nib_ready), 32'd1);
    k = 0;
    ph = 1'b0;
    chk5 = 1'b0;
    while (k < 32) begin
      if (abort_after >= 0 && k == abort_after) break;
      if (toggle && ph) begin
        apply_stimulus(1'b0, 1'b0, 4'($urandom));
      end else begin
        b = load_bytes[k / 2];
        if (k % 2 == 0) begin
          apply_stimulus(poke && (k == 6), 1'b1, b[7:4]);
        end else begin
          apply_stimulus(1'b0, 1'b1, b[3:0]);
          if (watch5 && k == 11) begin
            addr = 4'd5;
            #1;
            check_output("prog5_old_in_write_cycle", 32'(prog), 32'(exp_mem[5]));
            chk5 = 1'b1;
          end
          e.addr = 4'(k / 2);
          e.data = b;
          sb_q.push_back(e);
          exp_mem[k / 2] = b;
          exp_sum = exp_sum + b;
        end
        k++;
      end
      ph = ~ph;
      tick();
      if (chk5) begin
        check_output("prog5_new_after_write", 32'(prog), 32'h0000_00A5);
        chk5 = 1'b0;
      end
    end
    if (abort_after >= 0) return;
    apply_stimulus(poke, 1'b0, 4'h0);
    check_output("done_pulse", 32'(done), 32'd1);
    check_output("no_early_done", 32'(done_count), 32'(dc0));
    check_output("ready_in_done", 32'(nib_ready), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 4'h0);
    check_output("done_cleared", 32'(done), 32'd0);
    check_output("idle_after_done", 32'(busy), 32'd0);
    check_output("done_once", 32'(done_count), 32'(dc0 + 1));
    check_output("checksum", 32'(checksum), 32'(exp_sum));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      addr = e.addr;
      #1;
      check_output("scoreboard_prog", 32'(prog), 32'(e.data));
      tick();
    end
  endtask

  initial begin
    addr = 4'h0;
    clear_model();

    // Reset state and a sweep of the cleared memory.
    do_reset();
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_ready", 32'(nib_ready), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_checksum", 32'(checksum), 32'd0);
    for (int i = 0; i < 16; i++) begin
      vtab[i].addr = 4'(i);
      vtab[i].exp  = 8'h00;
    end
    apply_table("reset_sweep");

    // Back-to-back load of byte i = {i, i+1}.
    for (int i = 0; i < 16; i++) load_bytes[i] = {4'(i), 4'(i + 1)};
    run_load(1'b0, 1'b0, 1'b0, -1);
    check_output("ramp_checksum_const", 32'(checksum), 32'h0000_00F8);
    addr = 4'd3;
    #1;
    check_output("ramp_addr3", 32'(prog), 32'h0000_0034);
    addr = 4'd15;
    #1;
    check_output("ramp_addr15", 32'(prog), 32'h0000_00F0);
    tick();

    // The same image with nib_valid toggling every cycle.
    do_reset();
    run_load(1'b1, 1'b0, 1'b0, -1);
    for (int i = 0; i < 16; i++) begin
      vtab[i].addr = 4'(i);
      vtab[i].exp  = {4'(i), 4'(i + 1)};
    end
    apply_table("toggle_image");

    // Reset after 7 nibbles, with a handshake in the reset cycle.
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'h9C;
    run_load(1'b0, 1'b0, 1'b0, 7);
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b1, 4'hC);
    tick();
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 4'h0);
    clear_model();
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_ready", 32'(nib_ready), 32'd0);
    check_output("abort_checksum", 32'(checksum), 32'd0);
    for (int a = 0; a < 4; a++) begin
      addr = 4'(a);
      #1;
      check_output("abort_mem", 32'(prog), 32'd0);
      tick();
    end
    check_output("abort_no_done", 32'(done_count), 32'(dc0));

    // load_start pulses in HI and in DONE are ignored.
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(i * 7 + 3);
    run_load(1'b0, 1'b1, 1'b0, -1);

    // Location 5 is rewritten with 0xA5 while addr is held at 5.
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'h55;
    load_bytes[5] = 8'hA5;
    run_load(1'b0, 1'b0, 1'b1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
